// File: rtl/apb2csb_bridge_mc.sv
// apb2csb_bridge_mc
// APB slave to multi-channel CSB master bridge. Each APB access is decoded to
// one of NUM_CH CSB targets by a channel-select field in paddr, issued as a CSB
// request on that channel, and completed on the APB side with a one-cycle
// pready. Out-of-range channels and response timeouts complete with pslverr
// and are counted in a saturating error counter.
//
// State table
//   state   | meaning
//   IDLE    | waiting for an APB access phase (psel & penable)
//   REQ     | csb2nvdla_valid[ch] held until ready[ch]
//   WAIT_RD | read accepted, waiting for nvdla2csb_valid[ch]
//   WAIT_WR | non-posted write accepted, waiting for wr_complete[ch]
//   DONE    | pready pulse, pslverr = err
//
// Ports
//   pclk, prst              : clock, synchronous active-high reset
//   paddr/psel/penable/
//   pwrite/pwdata           : APB request
//   prdata/pready/pslverr   : APB completion
//   csb2nvdla_*             : per-channel CSB request, channel i in slice i
//   nvdla2csb_*             : per-channel CSB read data / write completion
//   err_cnt                 : saturating count of error completions

module apb2csb_bridge_mc #(
  parameter int NUM_CH      = 2,
  parameter int CSB_AW      = 16,
  parameter int DATA_W      = 32,
  parameter int CH_SEL_LSB  = 18,
  parameter int NPOSTED_WR  = 1,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                       pclk,
  input  logic                       prst,
  input  logic [31:0]                paddr,
  input  logic                       psel,
  input  logic                       penable,
  input  logic                       pwrite,
  input  logic [DATA_W-1:0]          pwdata,
  output logic [DATA_W-1:0]          prdata,
  output logic                       pready,
  output logic                       pslverr,
  output logic [NUM_CH-1:0]          csb2nvdla_valid,
  input  logic [NUM_CH-1:0]          csb2nvdla_ready,
  output logic [NUM_CH*CSB_AW-1:0]   csb2nvdla_addr,
  output logic [NUM_CH*DATA_W-1:0]   csb2nvdla_wdat,
  output logic [NUM_CH-1:0]          csb2nvdla_write,
  output logic [NUM_CH-1:0]          csb2nvdla_nposted,
  input  logic [NUM_CH-1:0]          nvdla2csb_valid,
  input  logic [NUM_CH*DATA_W-1:0]   nvdla2csb_data,
  input  logic [NUM_CH-1:0]          nvdla2csb_wr_complete,
  output logic [7:0]                 err_cnt
);

  localparam int          CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic        NP_EN    = (NPOSTED_WR != 0);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_RD,
    S_WAIT_WR,
    S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic [CH_W-1:0]     ch_q;
  logic [CSB_AW-1:0]   addr_q;
  logic [DATA_W-1:0]   wdat_q;
  logic                write_q;
  logic                err_q, err_nxt;
  logic [15:0]         timer_q, timer_nxt;
  logic [DATA_W-1:0]   prdata_q, prdata_nxt;

  logic                access;
  logic [CH_W-1:0]     ch_dec;
  logic                ch_ok;
  logic                ready_sel;
  logic                rvalid_sel;
  logic                cmpl_sel;
  logic [DATA_W-1:0]   rdata_sel;
  logic                expired;
  logic [15:0]         timer_inc;

  // Address bits outside the decoded fields are intentionally ignored.
  logic                unused_paddr;
  assign unused_paddr = ^paddr;

  assign access = psel & penable;
  assign ch_dec = paddr[CH_SEL_LSB +: CH_W];
  assign ch_ok  = (32'(ch_dec) < 32'(NUM_CH));

  // Only the latched channel's responses are looked at; everything else on
  // the return buses is treated as noise.
  always_comb begin
    ready_sel  = 1'b0;
    rvalid_sel = 1'b0;
    cmpl_sel   = 1'b0;
    rdata_sel  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_q == CH_W'(i)) begin
        ready_sel  = csb2nvdla_ready[i];
        rvalid_sel = nvdla2csb_valid[i];
        cmpl_sel   = nvdla2csb_wr_complete[i];
        rdata_sel  = nvdla2csb_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Timer counts cycles spent in REQ + WAIT_*. Compare uses >= so that a
  // request accepted on the expiry cycle still times out on its first
  // silent wait cycle instead of letting the counter run away.
  assign expired   = (timer_q >= TMO_LAST);
  assign timer_inc = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;

  always_comb begin
    state_nxt  = state;
    err_nxt    = err_q;
    timer_nxt  = timer_q;
    prdata_nxt = prdata_q;
    case (state)
      S_IDLE: begin
        if (access) begin
          timer_nxt  = '0;
          prdata_nxt = '0;
          if (ch_ok) begin
            state_nxt = S_REQ;
            err_nxt   = 1'b0;
          end else begin
            state_nxt = S_DONE;
            err_nxt   = 1'b1;
          end
        end
      end
      S_REQ: begin
        timer_nxt = timer_inc;
        if (ready_sel) begin
          if (!write_q)   state_nxt = S_WAIT_RD;
          else if (NP_EN) state_nxt = S_WAIT_WR;
          else            state_nxt = S_DONE;
        end else if (expired) begin
          state_nxt = S_DONE;
          err_nxt   = 1'b1;
        end
      end
      S_WAIT_RD: begin
        timer_nxt = timer_inc;
        if (rvalid_sel) begin
          state_nxt  = S_DONE;
          prdata_nxt = rdata_sel;
        end else if (expired) begin
          state_nxt = S_DONE;
          err_nxt   = 1'b1;
        end
      end
      S_WAIT_WR: begin
        timer_nxt = timer_inc;
        if (cmpl_sel) begin
          state_nxt = S_DONE;
        end else if (expired) begin
          state_nxt = S_DONE;
          err_nxt   = 1'b1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      state    <= S_IDLE;
      ch_q     <= '0;
      addr_q   <= '0;
      wdat_q   <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      timer_q  <= '0;
      prdata_q <= '0;
      err_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      err_q    <= err_nxt;
      timer_q  <= timer_nxt;
      prdata_q <= prdata_nxt;
      if (state == S_IDLE && access) begin
        ch_q    <= ch_dec;
        addr_q  <= paddr[CSB_AW+1:2];
        wdat_q  <= pwdata;
        write_q <= pwrite;
      end
      if (state == S_DONE && err_q && err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    csb2nvdla_valid   = '0;
    csb2nvdla_addr    = '0;
    csb2nvdla_wdat    = '0;
    csb2nvdla_write   = '0;
    csb2nvdla_nposted = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (state == S_REQ && ch_q == CH_W'(i)) begin
        csb2nvdla_valid[i]                   = 1'b1;
        csb2nvdla_addr[i*CSB_AW +: CSB_AW]   = addr_q;
        csb2nvdla_wdat[i*DATA_W +: DATA_W]   = wdat_q;
        csb2nvdla_write[i]                   = write_q;
        csb2nvdla_nposted[i]                 = write_q & NP_EN;
      end
    end
  end

  assign pready  = (state == S_DONE);
  assign pslverr = (state == S_DONE) & err_q;
  assign prdata  = prdata_q;

endmodule

// File: tb/tb_apb2csb_bridge_mc.sv
// Bench for apb2csb_bridge_mc built with NUM_CH=3, TIMEOUT_CYC=8.
// A transaction-level model predicts, per access, the CSB valid window, the
// completion cycle, pslverr, prdata and the running error count; a negedge
// process compares the DUT against it every cycle. Directed tests add literal
// expectations for latencies and data.

module tb_apb2csb_bridge_mc;

  localparam int NC   = 3;
  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int LSB  = 18;
  localparam int NPW  = 1;
  localparam int TMO  = 8;

  logic                pclk;
  logic                prst;
  logic [31:0]         paddr;
  logic                psel;
  logic                penable;
  logic                pwrite;
  logic [DW-1:0]       pwdata;
  logic [DW-1:0]       prdata;
  logic                pready;
  logic                pslverr;
  logic [NC-1:0]       csb_valid;
  logic [NC-1:0]       csb_ready;
  logic [NC*AW-1:0]    csb_addr;
  logic [NC*DW-1:0]    csb_wdat;
  logic [NC-1:0]       csb_write;
  logic [NC-1:0]       csb_nposted;
  logic [NC-1:0]       rsp_valid;
  logic [NC*DW-1:0]    rsp_data;
  logic [NC-1:0]       rsp_cmpl;
  logic [7:0]          err_cnt;

  apb2csb_bridge_mc #(
    .NUM_CH(NC), .CSB_AW(AW), .DATA_W(DW), .CH_SEL_LSB(LSB),
    .NPOSTED_WR(NPW), .TIMEOUT_CYC(TMO)
  ) dut (
    .pclk(pclk), .prst(prst), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .csb2nvdla_valid(csb_valid), .csb2nvdla_ready(csb_ready),
    .csb2nvdla_addr(csb_addr), .csb2nvdla_wdat(csb_wdat),
    .csb2nvdla_write(csb_write), .csb2nvdla_nposted(csb_nposted),
    .nvdla2csb_valid(rsp_valid), .nvdla2csb_data(rsp_data),
    .nvdla2csb_wr_complete(rsp_cmpl), .err_cnt(err_cnt)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // model expectations for the current transaction
  bit          chk_en;
  int          exp_lo, exp_hi, exp_done, exp_ch;
  bit          exp_err, exp_write;
  logic [31:0] exp_rdata, exp_wdat;
  logic [15:0] exp_addr;
  int          model_cnt;

  // observations used by directed literal checks
  int          obs_pready_cyc, obs_valid_cnt, last_a;
  logic [NC-1:0] obs_valid_or;
  logic        obs_pslverr;
  logic [31:0] obs_prdata;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge pclk) begin
    logic [NC-1:0] ev;
    if (chk_en) begin
      ev = '0;
      if (cyc >= exp_lo && cyc <= exp_hi) ev[exp_ch] = 1'b1;
      check("csb_valid", 32'(csb_valid), 32'(ev));
      if (ev != '0) begin
        check("csb_addr", 32'(csb_addr[exp_ch*AW +: AW]), 32'(exp_addr));
        check("csb_wdat", csb_wdat[exp_ch*DW +: DW], exp_wdat);
        check("csb_write", 32'(csb_write[exp_ch]), 32'(exp_write));
        check("csb_nposted", 32'(csb_nposted[exp_ch]), 32'((NPW != 0) && exp_write));
      end
      check("pready", 32'(pready), 32'(cyc == exp_done));
      if (cyc == exp_done) begin
        check("pslverr", 32'(pslverr), 32'(exp_err));
        check("prdata", prdata, exp_rdata);
      end
      check("err_cnt", 32'(err_cnt), 32'(model_cnt));
      if (pready) begin
        obs_pready_cyc = cyc;
        obs_pslverr    = pslverr;
        obs_prdata     = prdata;
      end
      obs_valid_or = obs_valid_or | csb_valid;
      if (csb_valid != '0) obs_valid_cnt++;
      if (cyc == exp_done && exp_err && model_cnt < 255) model_cnt++;
    end
  end

  // One APB access. d: cycles ready is held low after request entry;
  // r: cycles after acceptance that the response arrives (-1 = never);
  // abort_at: cycle offset from the access cycle at which prst is pulsed.
  task automatic xfer(input logic [31:0] pa, input bit wr, input logic [31:0] wd,
                      input int d, input int r, input logic [31:0] rd,
                      input int abort_at);
    int a, rq, ch, oth, last;
    bit oor;
    ch  = int'((pa >> LSB) & 32'h3);
    oor = (ch >= NC);
    oth = (ch + 1) % NC;
    psel = 1'b1; penable = 1'b0; paddr = pa; pwrite = wr; pwdata = wd;
    @(posedge pclk); #1;
    a = cyc; rq = a + 1; last_a = a;
    obs_valid_or = '0; obs_valid_cnt = 0; obs_pready_cyc = -1;
    exp_ch = oor ? 0 : ch; exp_addr = pa[17:2]; exp_wdat = wd; exp_write = wr;
    exp_rdata = '0; exp_err = 1'b0;
    if (oor) begin
      exp_lo = -1; exp_hi = -2; exp_done = a + 1; exp_err = 1'b1;
    end else if (d > TMO - 1) begin
      exp_lo = rq; exp_hi = rq + TMO - 1; exp_done = rq + TMO; exp_err = 1'b1;
    end else begin
      exp_lo = rq; exp_hi = rq + d;
      if (r < 0 || d + r > TMO - 1) begin
        exp_done = rq + TMO; exp_err = 1'b1;
      end else begin
        exp_done = rq + d + r + 1;
        if (!wr) exp_rdata = rd;
      end
    end
    penable = 1'b1;
    last = (abort_at >= 0) ? a + abort_at : exp_done;
    while (cyc <= last) begin
      csb_ready = '0; rsp_valid = '0; rsp_cmpl = '0; rsp_data = '0;
      // constant noise on a neighbouring channel
      rsp_valid[oth] = 1'b1; rsp_cmpl[oth] = 1'b1;
      rsp_data[oth*DW +: DW] = 32'hFFFF_FFFF;
      if (!oor && cyc >= rq + d) csb_ready[ch] = 1'b1;
      if (!oor && r >= 0 && cyc == rq + d + r) begin
        if (wr) rsp_cmpl[ch] = 1'b1;
        else begin
          rsp_valid[ch] = 1'b1;
          rsp_data[ch*DW +: DW] = rd;
        end
      end
      if (abort_at >= 0 && cyc == a + abort_at) begin
        prst = 1'b1; chk_en = 1'b0;
      end
      @(posedge pclk); #1;
    end
    psel = 1'b0; penable = 1'b0;
    csb_ready = '0; rsp_valid = '0; rsp_cmpl = '0; rsp_data = '0;
    if (abort_at >= 0) begin
      prst = 1'b0;
      exp_lo = -1; exp_hi = -2; exp_done = -1; model_cnt = 0;
      chk_en = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_before;
    prst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    csb_ready = '0; rsp_valid = '0; rsp_cmpl = '0; rsp_data = '0;
    chk_en = 1'b0; exp_lo = -1; exp_hi = -2; exp_done = -1; exp_ch = 0;
    exp_err = 0; exp_write = 0; exp_rdata = 0; exp_wdat = 0; exp_addr = 0;
    model_cnt = 0; obs_valid_or = '0; obs_valid_cnt = 0; obs_pready_cyc = -1;
    obs_pslverr = 0; obs_prdata = 0; last_a = 0;
    repeat (2) @(posedge pclk);
    #1; prst = 1'b0;
    check("rst_pready", 32'(pready), 32'd0);
    check("rst_pslverr", 32'(pslverr), 32'd0);
    check("rst_prdata", prdata, 32'd0);
    check("rst_valid", 32'(csb_valid), 32'd0);
    check("rst_addr", csb_addr[31:0], 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk_en = 1'b1;

    // 1: non-posted write ch1, immediate ready, completion next cycle
    xfer(32'h0004_0010, 1'b1, 32'hA5A5_0001, 0, 1, 32'h0, -1);
    check("t1_valid_ch", 32'(obs_valid_or), 32'h2);
    check("t1_latency", 32'(obs_pready_cyc - last_a), 32'd3);
    check("t1_pslverr", 32'(obs_pslverr), 32'd0);
    check("t1_err_cnt", 32'(err_cnt), 32'd0);

    // 2: read ch0, ready low 3 cycles, data next cycle after accept
    xfer(32'h0000_0040, 1'b0, 32'h0, 3, 1, 32'h1234_5678, -1);
    check("t2_valid_cycles", 32'(obs_valid_cnt), 32'd4);
    check("t2_prdata", obs_prdata, 32'h1234_5678);
    check("t2_latency", 32'(obs_pready_cyc - last_a), 32'd6);

    // zero-wait read: pready 3 cycles after access
    xfer(32'h0008_0104, 1'b0, 32'h0, 0, 1, 32'h0BAD_F00D, -1);
    check("rd_latency", 32'(obs_pready_cyc - last_a), 32'd3);
    check("rd_prdata", obs_prdata, 32'h0BAD_F00D);

    // 3: out-of-range channel 3
    xfer(32'h000C_0000, 1'b0, 32'h0, 0, 1, 32'h0, -1);
    check("t3_no_valid", 32'(obs_valid_or), 32'd0);
    check("t3_latency", 32'(obs_pready_cyc - last_a), 32'd1);
    check("t3_pslverr", 32'(obs_pslverr), 32'd1);
    check("t3_err_cnt", 32'(err_cnt), 32'd1);

    // 4: read timeout, then a late response that must be ignored
    xfer(32'h0004_0020, 1'b0, 32'h0, 0, -1, 32'h0, -1);
    check("t4_latency", 32'(obs_pready_cyc - (last_a + 1)), 32'd8);
    check("t4_pslverr", 32'(obs_pslverr), 32'd1);
    check("t4_prdata", obs_prdata, 32'd0);
    rsp_valid[1] = 1'b1; rsp_data[63:32] = 32'hFFFF_FFFF;
    @(posedge pclk); #1;
    rsp_valid = '0; rsp_data = '0;
    check("t4_late_prdata", prdata, 32'd0);
    xfer(32'h0004_0024, 1'b0, 32'h0, 0, 1, 32'h1122_3344, -1);
    check("t4_next_prdata", obs_prdata, 32'h1122_3344);

    // request never accepted: times out in REQ
    xfer(32'h0008_0008, 1'b1, 32'h5555_AAAA, 20, 1, 32'h0, -1);
    check("req_tmo_valid_cycles", 32'(obs_valid_cnt), 32'd8);
    // write completion arriving one cycle too late
    xfer(32'h0000_0200, 1'b1, 32'h0000_0077, 0, 8, 32'h0, -1);
    check("wr_tmo_pslverr", 32'(obs_pslverr), 32'd1);
    // write ch2 with delayed ready and completion
    xfer(32'h0008_003C, 1'b1, 32'hDEAD_0002, 1, 2, 32'h0, -1);
    check("wr_ch2_pslverr", 32'(obs_pslverr), 32'd0);

    // 5: response exactly on the expiry cycle wins
    cnt_before = int'(err_cnt);
    xfer(32'h0000_0080, 1'b0, 32'h0, 0, 7, 32'h0000_CAFE, -1);
    check("t5_pslverr", 32'(obs_pslverr), 32'd0);
    check("t5_prdata", obs_prdata, 32'h0000_CAFE);
    check("t5_latency", 32'(obs_pready_cyc - last_a), 32'd9);
    check("t5_err_cnt", 32'(err_cnt), 32'(cnt_before));

    // 6: reset while in WAIT_RD, then normal read, then saturation
    xfer(32'h0000_0010, 1'b0, 32'h0, 0, -1, 32'h0, 3);
    check("t6_pready", 32'(pready), 32'd0);
    check("t6_prdata", prdata, 32'd0);
    check("t6_valid", 32'(csb_valid), 32'd0);
    check("t6_err_cnt", 32'(err_cnt), 32'd0);
    check("t6_no_pready", 32'(obs_pready_cyc), 32'hFFFF_FFFF);
    xfer(32'h0000_0014, 1'b0, 32'h0, 0, 1, 32'h600D_0006, -1);
    check("t6_read_prdata", obs_prdata, 32'h600D_0006);
    for (int k = 0; k < 300; k++) begin
      xfer(32'h0000_0100, 1'b0, 32'h0, 0, -1, 32'h0, -1);
    end
    @(posedge pclk); #1;
    check("t6_err_cnt_sat", 32'(err_cnt), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
